// File: rtl/byte_gather_fifo.sv
// Circular byte FIFO: one byte written per cycle, up to MAX_BYTES_OUT oldest bytes presented and popped per cycle.
// Optional feature: define FIFO_ERR_FLAG_EN to enable the sticky err_out protocol-error flag.
module byte_gather_fifo #(
    parameter int FIFO_SIZE     = 128,
    parameter int MAX_BYTES_OUT = 16,
    localparam int AW = $clog2(FIFO_SIZE),
    localparam int CW = $clog2(MAX_BYTES_OUT) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          wr_en_in,
    input  logic                          rd_en_in,
    input  logic [CW-1:0]                 num_bytes_in,
    output logic [MAX_BYTES_OUT-1:0][7:0] data_out,
    output logic [CW-1:0]                 valid_bytes_out,
    output logic                          fifo_empty_out,
    output logic                          fifo_full_out,
    output logic [AW:0]                   occupancy,
    output logic                          err_out
);

    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_SIZE);
    localparam logic [OW-1:0] WIN_OCC  = OW'(MAX_BYTES_OUT);

    logic [7:0]    buffer [FIFO_SIZE];
    logic [AW-1:0] front_ptr;
    logic [AW-1:0] back_ptr;
    logic          wr_acc;
    logic          rd_acc;
    logic [OW-1:0] occ_next;

    // Status flags come from registered occupancy only, so no input reaches an output.
    assign fifo_empty_out  = (occupancy == '0);
    assign fifo_full_out   = (occupancy == FULL_OCC);
    assign valid_bytes_out = (occupancy > WIN_OCC) ? CW'(MAX_BYTES_OUT) : CW'(occupancy);

    // A pop in the same cycle does not make room for a write into a full buffer.
    assign wr_acc   = wr_en_in && !fifo_full_out;
    assign rd_acc   = rd_en_in && (num_bytes_in != '0) && (num_bytes_in <= valid_bytes_out);
    assign occ_next = occupancy + OW'(wr_acc) - (rd_acc ? OW'(num_bytes_in) : '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_ptr <= '0;
            back_ptr  <= '0;
            occupancy <= '0;
        end else begin
            if (wr_acc) begin
                back_ptr <= back_ptr + AW'(1);
            end
            if (rd_acc) begin
                front_ptr <= front_ptr + AW'(num_bytes_in);
            end
            occupancy <= occ_next;
        end
    end

    // NOTE: the byte array has no reset; stale contents are never visible because the window is masked by occupancy.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            buffer[back_ptr] <= data_in;
        end
    end

    // NOTE: data_out gets a default before the loop so no lane can infer a latch.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < MAX_BYTES_OUT; i++) begin
            if (CW'(i) < valid_bytes_out) begin
                data_out[i] = buffer[front_ptr + AW'(i)];
            end
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic err_q;
    logic wr_rej;
    logic rd_rej;

    // An oversize count always exceeds valid_bytes_out, so one compare covers both pop errors.
    assign wr_rej = wr_en_in && fifo_full_out;
    assign rd_rej = rd_en_in && (num_bytes_in > valid_bytes_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (wr_rej || rd_rej) begin
            err_q <= 1'b1;
        end
    end

    assign err_out = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && wr_rej) begin
            $error("byte_gather_fifo: write rejected, buffer full");
        end
        if (!reset && rd_rej) begin
            $error("byte_gather_fifo: pop of %0d rejected, %0d valid", num_bytes_in, valid_bytes_out);
        end
    end
`endif
`else
    assign err_out = 1'b0;
`endif

`ifndef SYNTHESIS
    occ_bound: assert property (@(posedge clk) disable iff (reset) occupancy <= FULL_OCC);
    ptr_track: assert property (@(posedge clk) disable iff (reset)
                                (back_ptr - front_ptr) == occupancy[AW-1:0]);
`endif

endmodule

// File: tb/tb_byte_gather_fifo.sv
// Scoreboard bench for byte_gather_fifo: a byte-queue reference model predicts every post-edge state,
// and a negedge monitor compares all outputs against the predictions.
module tb_byte_gather_fifo;

    localparam int FIFO_SIZE     = 128;
    localparam int MAX_BYTES_OUT = 16;
    localparam int AW            = $clog2(FIFO_SIZE);
    localparam int CW            = $clog2(MAX_BYTES_OUT) + 1;
    localparam int WW            = MAX_BYTES_OUT * 8;
`ifdef FIFO_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          reset = 1'b1;
    logic [7:0]                    data_in = '0;
    logic                          wr_en_in = 1'b0;
    logic                          rd_en_in = 1'b0;
    logic [CW-1:0]                 num_bytes_in = '0;
    logic [MAX_BYTES_OUT-1:0][7:0] data_out;
    logic [CW-1:0]                 valid_bytes_out;
    logic                          fifo_empty_out;
    logic                          fifo_full_out;
    logic [AW:0]                   occupancy;
    logic                          err_out;

    byte_gather_fifo #(
        .FIFO_SIZE     (FIFO_SIZE),
        .MAX_BYTES_OUT (MAX_BYTES_OUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_in         (data_in),
        .wr_en_in        (wr_en_in),
        .rd_en_in        (rd_en_in),
        .num_bytes_in    (num_bytes_in),
        .data_out        (data_out),
        .valid_bytes_out (valid_bytes_out),
        .fifo_empty_out  (fifo_empty_out),
        .fifo_full_out   (fifo_full_out),
        .occupancy       (occupancy),
        .err_out         (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            occ;
        int            valid;
        bit            empty;
        bit            full;
        bit            err;
        logic [WW-1:0] win;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_q[$];
    bit         ref_err = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs, predict the state after the coming edge, then step past that edge.
    task automatic cycle(input bit rst, input bit wr, input logic [7:0] d, input bit rd, input int n);
        exp_t e;
        int   v;
        bit   full;
        reset        = rst;
        wr_en_in     = wr;
        data_in      = d;
        rd_en_in     = rd;
        num_bytes_in = CW'(n);
        if (rst) begin
            ref_q.delete();
            ref_err = 1'b0;
        end else begin
            v    = (ref_q.size() < MAX_BYTES_OUT) ? ref_q.size() : MAX_BYTES_OUT;
            full = (ref_q.size() == FIFO_SIZE);
            if (ERR_EN && ((wr && full) || (rd && n > v))) ref_err = 1'b1;
            if (rd && n >= 1 && n <= v) begin
                for (int k = 0; k < n; k++) void'(ref_q.pop_front());
            end
            if (wr && !full) ref_q.push_back(d);
        end
        e.occ   = ref_q.size();
        e.valid = (ref_q.size() < MAX_BYTES_OUT) ? ref_q.size() : MAX_BYTES_OUT;
        e.empty = (ref_q.size() == 0);
        e.full  = (ref_q.size() == FIFO_SIZE);
        e.err   = ref_err;
        e.win   = '0;
        for (int k = 0; k < e.valid; k++) e.win[k*8 +: 8] = ref_q[k];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        cycle(1'b0, 1'b1, d, 1'b0, 0);
    endtask

    task automatic pop(input int n);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, n);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 0);
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m = exp_q.pop_front();
            check("occupancy", WW'(occupancy), WW'(m.occ));
            check("valid_bytes", WW'(valid_bytes_out), WW'(m.valid));
            check("empty", WW'(fifo_empty_out), WW'(m.empty));
            check("full", WW'(fifo_full_out), WW'(m.full));
            check("err", WW'(err_out), WW'(m.err));
            check("data_out", data_out, m.win);
        end
    end

    initial begin
        int wp;
        int rp;
        int n;
        bit w;
        bit r;
        bit rs;

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 0);

        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        cycle(1'b0, 1'b1, 8'h06, 1'b1, 3);
        idle();
        pop(3);
        idle();

        for (int i = 0; i < FIFO_SIZE; i++) wr_byte(8'(i));
        wr_byte(8'hAA);
        cycle(1'b0, 1'b1, 8'hBB, 1'b1, 16);
        idle();

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < 120; i++) wr_byte(8'(i));
        for (int i = 0; i < 7; i++) pop(16);
        pop(8);
        for (int i = 0; i < 16; i++) wr_byte(8'(8'h10 + i));
        idle();
        pop(16);
        idle();

        wr_byte(8'hC1);
        wr_byte(8'hC2);
        pop(4);
        pop(0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 5);
        idle();

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < 50; i++) wr_byte(8'(8'h30 + i));
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 3);
        idle();

        // Alternate fill-heavy and drain-heavy phases so full, empty and wrap all recur.
        for (int c = 0; c < 3000; c++) begin
            wp = ((c / 300) % 2 == 0) ? 85 : 35;
            rp = ((c / 300) % 2 == 0) ? 5 : 60;
            w  = ($urandom_range(99) < wp);
            r  = ($urandom_range(99) < rp);
            n  = ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(16);
            rs = ($urandom_range(999) == 0);
            cycle(rs, w, 8'($urandom), r, n);
        end

        idle();
        @(negedge clk);
        #1;
        check("scoreboard_drained", WW'(exp_q.size()), WW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
